anode_capture: RTL and testbench
================================

# anode_capture

Receive-side monitor for the multiplexed four-digit seven-segment bus that the display anode driver produces. It samples the active-low anode strobes and the shared 4-bit character bus, then rebuilds the four displayed characters. It checks the scan order (digit 3, then 2, then 1, then 0) and publishes a complete frame once all four digits arrive in order. It sits on the board-test / loopback path, fed by the same nets that go to the display.

## Interface
Parameters:
- MIN_ON, 1: minimum consecutive sampled cycles an anode must be low, with char stable, for a digit to be accepted.
- TIMEOUT, 64: cycles allowed between accepted digits before the frame is abandoned.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-low reset.
- an0, an1, an2, an3  input  1 each  anode strobes, active-low (0 = digit lit).
- char  input  4  character currently driven on the shared bus.
- digit0..digit3  output  4 each  last complete frame; digitN is the char captured under anN.
- frame_valid  output  1  one-cycle pulse when digit0..3 update.
- order_err  output  1  one-cycle pulse on an out-of-sequence digit.
- multi_err  output  1  one-cycle pulse when more than one anode is low in the same sample.
- timeout  output  1  one-cycle pulse when TIMEOUT expires mid-frame.
- err_cnt  output  8  saturating count of error events.

## Operation
- **Input register.** an0..an3 and char are registered every cycle into an_q and char_q. All decisions use the registered values.
- **Run tracking.** There is one run tracker.
  - A run starts when exactly one an_q bit is low; it records the index and char_q.
  - Each further cycle with the same anode low and the same char_q increments the run length, saturating at MIN_ON.
  - If char_q changes during a run, the run is marked invalid.
  - The run ends when that anode is sampled high.
  - On run end: if the run is valid and its length is at least MIN_ON, raise accept(index, char) for one cycle. Otherwise discard the run silently (no error).
- **FSM states:** WAIT3, WAIT2, WAIT1, WAIT0. Reset state is WAIT3.
  - accept with the expected index: store char in the shadow register and advance (WAIT3→WAIT2→WAIT1→WAIT0).
  - accept in WAIT0 with index 0: copy the shadow registers plus the new char to digit0..3, pulse frame_valid, go to WAIT3.
  - accept with an unexpected index: pulse order_err. If the index is 3, store it and go to WAIT2; otherwise go to WAIT3.
  - multi_err (two or more an_q bits low): abort the current run and go to WAIT3.
- **Timeout.**
  - The timeout counter reloads to TIMEOUT on every accept and whenever the FSM is in WAIT3.
  - Outside WAIT3 it decrements.
  - On reaching 0: pulse timeout and go to WAIT3.
- **Error counter.** err_cnt increments by exactly 1 in any cycle where order_err, multi_err or timeout is high, and saturates at 255.

## Timing
- **Reset values:** digit0..3 = 0, frame_valid = order_err = multi_err = timeout = 0, err_cnt = 0, FSM = WAIT3, run tracker idle, an_q = 4'b1111.
- **Latency:** edge E samples an anode high that ends a run; accept is combinational in the following cycle; at edge E+1 the digit registers, frame_valid and order_err update. Total input-to-output latency is 2 edges.
- multi_err is asserted one edge after the offending sample is registered.
- **Simultaneous events:**
  - accept and timeout expiry in the same cycle: accept wins and the counter reloads.
  - multi_err and a run ending in the same cycle: multi_err wins and there is no accept.
- A run still open when a new anode goes low while the old one stays low counts as multi_err.
- All-high samples between digits are legal and unlimited, subject only to TIMEOUT.
- Reset asserted mid-frame clears shadow registers and state immediately (asynchronous); digit0..3 return to 0.
- digit0..3 hold their value between frames.

## Structure
- **parameters.vh (shared):**
  - FSM state encodings (WAIT3..WAIT0, 2 bits).
  - digit index constants.
  - the existing character codes (`zero, `one, ...) used by the bench.
- **Sub-module anode_run_detector:**
  - Inputs: an_q, char_q.
  - Outputs: accept, acc_idx, acc_char, multi.
  - Contents: run length counter and valid flag.
- anode_capture keeps the input register, FSM, shadow/output registers, timeout counter and err_cnt.

## Test plan
- **Nominal loopback.** Drive the display driver's 16-cycle pattern (an3 low one cycle with char `zero, an2 with `one, an1 with `two, an0 with `three), MIN_ON=1. Required: digit3=0, digit2=1, digit1=2, digit0=3, one frame_valid per 16 cycles, err_cnt=0.
- **Order violation.** Sequence an3, an1. Required: order_err pulse, err_cnt=1, FSM in WAIT3, digits unchanged. A following full 3-2-1-0 sequence then yields frame_valid.
- **Multiple anodes.** Drive an2 and an1 low together for one cycle. Required: multi_err pulse 2 edges later, no accept, err_cnt increments.
- **Glitch and minimum width.** With MIN_ON=2: a 1-cycle strobe is ignored, and a 3-cycle strobe with char changing mid-run is ignored. Required in both cases: no error pulses, and a clean 2-cycle strobe is accepted.
- **Timeout.** Accept digit 3, then keep all anodes high for 64 cycles. Required: timeout pulse, FSM in WAIT3. Also hold err_cnt at 254 and trigger 3 errors; required: saturation at 255.
- **Reset mid-frame.** Reset low after digits 3 and 2 are accepted. Required: all outputs 0 immediately, and the next frame requires a full 3-2-1-0 sequence.

Source files
------------

// File: rtl/anode_capture_pkg.sv
// Shared definitions for the seven-segment anode loopback monitor.
package anode_capture_pkg;

  localparam int NUM_AN = 4;

  // Scan order is digit 3 first, digit 0 last.
  typedef enum logic [1:0] {
    WAIT3 = 2'd0,
    WAIT2 = 2'd1,
    WAIT1 = 2'd2,
    WAIT0 = 2'd3
  } cap_state_t;

  localparam logic [1:0] IDX0 = 2'd0;
  localparam logic [1:0] IDX1 = 2'd1;
  localparam logic [1:0] IDX2 = 2'd2;
  localparam logic [1:0] IDX3 = 2'd3;

  // Character codes carried on the shared bus.
  localparam logic [3:0] CH_ZERO  = 4'h0;
  localparam logic [3:0] CH_ONE   = 4'h1;
  localparam logic [3:0] CH_TWO   = 4'h2;
  localparam logic [3:0] CH_THREE = 4'h3;
  localparam logic [3:0] CH_FOUR  = 4'h4;
  localparam logic [3:0] CH_FIVE  = 4'h5;
  localparam logic [3:0] CH_SIX   = 4'h6;
  localparam logic [3:0] CH_SEVEN = 4'h7;
  localparam logic [3:0] CH_EIGHT = 4'h8;
  localparam logic [3:0] CH_NINE  = 4'h9;

  function automatic logic [1:0] expected_idx(input cap_state_t s);
    case (s)
      WAIT3:   return IDX3;
      WAIT2:   return IDX2;
      WAIT1:   return IDX1;
      default: return IDX0;
    endcase
  endfunction

  function automatic cap_state_t next_wait(input cap_state_t s);
    case (s)
      WAIT3:   return WAIT2;
      WAIT2:   return WAIT1;
      WAIT1:   return WAIT0;
      default: return WAIT3;
    endcase
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/anode_capture_run.sv
// Single run tracker: follows one lit anode and flags a clean, long-enough strobe.
module anode_run_detector
  import anode_capture_pkg::*;
#(
  parameter int MIN_ON = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  an_q,
  input  logic [3:0]  char_q,
  output logic        accept,
  output logic [1:0]  acc_idx,
  output logic [3:0]  acc_char,
  output logic        multi
);

  localparam int LW = (MIN_ON < 2) ? 1 : $clog2(MIN_ON + 1);
  localparam logic [LW-1:0] LEN_MAX = LW'(MIN_ON);

  logic          run_act;
  logic          run_ok;
  logic [1:0]    run_idx;
  logic [3:0]    run_char;
  logic [LW-1:0] run_len;
  logic [2:0]    low_cnt;
  logic [1:0]    low_idx;
  logic          one_low;
  logic          run_end;

  // Count low strobes and remember which one is low.
  always_comb begin
    low_cnt = '0;
    low_idx = '0;
    for (int i = 0; i < NUM_AN; i++) begin
      if (!an_q[i]) begin
        low_cnt = low_cnt + 3'd1;
        low_idx = 2'(i);
      end
    end
  end

  assign multi    = (low_cnt > 3'd1);
  assign one_low  = (low_cnt == 3'd1);
  assign run_end  = run_act && an_q[run_idx];
  // A collision in the same sample suppresses the accept.
  assign accept   = run_end && run_ok && (run_len >= LEN_MAX) && !multi;
  assign acc_idx  = run_idx;
  assign acc_char = run_char;

  // Run state: start on a single low strobe, extend while held, drop on release or collision.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run_act  <= 1'b0;
      run_ok   <= 1'b0;
      run_idx  <= '0;
      run_char <= '0;
      run_len  <= '0;
    end else if (multi) begin
      run_act <= 1'b0;
    end else if (run_act && !an_q[run_idx]) begin
      if (char_q != run_char) run_ok <= 1'b0;
      else if (run_len != LEN_MAX) run_len <= run_len + LW'(1);
    end else if (one_low) begin
      // Covers back-to-back strobes: old run ends and new one starts together.
      run_act  <= 1'b1;
      run_ok   <= 1'b1;
      run_idx  <= low_idx;
      run_char <= char_q;
      run_len  <= LW'(1);
    end else begin
      run_act <= 1'b0;
    end
  end

endmodule

// File: rtl/anode_capture.sv
// Loopback monitor: rebuilds the four displayed characters from the anode/char bus.
module anode_capture
  import anode_capture_pkg::*;
#(
  parameter int MIN_ON  = 1,
  parameter int TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       an0,
  input  logic       an1,
  input  logic       an2,
  input  logic       an3,
  input  logic [3:0] char,
  output logic [3:0] digit0,
  output logic [3:0] digit1,
  output logic [3:0] digit2,
  output logic [3:0] digit3,
  output logic       frame_valid,
  output logic       order_err,
  output logic       multi_err,
  output logic       timeout,
  output logic [7:0] err_cnt
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_INIT = TW'(TIMEOUT);

  logic [3:0]    an_q;
  logic [3:0]    char_q;
  logic          accept;
  logic [1:0]    acc_idx;
  logic [3:0]    acc_char;
  logic          multi;
  cap_state_t    state_q, state_d;
  logic [3:0]    sh3, sh2, sh1;
  logic [TW-1:0] tmo_q;
  logic          tmo_fire;
  logic          sh_we, fr_we;
  logic          fv_d, oe_d, to_d;

  // Input register; every decision below works on the sampled bus.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      an_q   <= 4'b1111;
      char_q <= '0;
    end else begin
      an_q   <= {an3, an2, an1, an0};
      char_q <= char;
    end
  end

  anode_run_detector #(.MIN_ON(MIN_ON)) u_run (
    .clk      (clk),
    .reset    (reset),
    .an_q     (an_q),
    .char_q   (char_q),
    .accept   (accept),
    .acc_idx  (acc_idx),
    .acc_char (acc_char),
    .multi    (multi)
  );

  // Scan-order FSM: next state and event pulses.
  always_comb begin
    state_d  = state_q;
    sh_we    = 1'b0;
    fr_we    = 1'b0;
    fv_d     = 1'b0;
    oe_d     = 1'b0;
    to_d     = 1'b0;
    // An accept in the expiry cycle wins over the timeout.
    tmo_fire = (state_q != WAIT3) && (tmo_q == '0) && !accept;
    if (multi) begin
      state_d = WAIT3;
    end else if (accept) begin
      if (acc_idx == expected_idx(state_q)) begin
        if (state_q == WAIT0) begin
          fr_we   = 1'b1;
          fv_d    = 1'b1;
          state_d = WAIT3;
        end else begin
          sh_we   = 1'b1;
          state_d = next_wait(state_q);
        end
      end else begin
        oe_d = 1'b1;
        // A stray digit 3 is a valid frame start, so keep it.
        if (acc_idx == IDX3) begin
          sh_we   = 1'b1;
          state_d = WAIT2;
        end else begin
          state_d = WAIT3;
        end
      end
    end
    if (tmo_fire) begin
      to_d    = 1'b1;
      state_d = WAIT3;
    end
  end

  // State, shadow characters and published frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= WAIT3;
      sh3     <= '0;
      sh2     <= '0;
      sh1     <= '0;
      digit0  <= '0;
      digit1  <= '0;
      digit2  <= '0;
      digit3  <= '0;
    end else begin
      state_q <= state_d;
      if (sh_we) begin
        case (acc_idx)
          IDX3:    sh3 <= acc_char;
          IDX2:    sh2 <= acc_char;
          IDX1:    sh1 <= acc_char;
          default: ;
        endcase
      end
      if (fr_we) begin
        digit3 <= sh3;
        digit2 <= sh2;
        digit1 <= sh1;
        digit0 <= acc_char;
      end
    end
  end

  // Inter-digit watchdog: parked at full value while idle in WAIT3.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) tmo_q <= TMO_INIT;
    else if (accept || state_q == WAIT3) tmo_q <= TMO_INIT;
    else if (tmo_q != '0) tmo_q <= tmo_q - TW'(1);
  end

  // One-cycle event pulses and saturating error tally (one count per cycle).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_valid <= 1'b0;
      order_err   <= 1'b0;
      multi_err   <= 1'b0;
      timeout     <= 1'b0;
      err_cnt     <= '0;
    end else begin
      frame_valid <= fv_d;
      order_err   <= oe_d;
      multi_err   <= multi;
      timeout     <= to_d;
      if (oe_d || multi || to_d) err_cnt <= sat_inc8(err_cnt);
    end
  end

endmodule

// File: tb/tb_anode_capture.sv
// Scoreboard bench: stimulus pushes expected events, a monitor pops on every output pulse.
module tb_anode_capture;
  import anode_capture_pkg::*;

  localparam int TMO = 64;
  localparam logic [3:0] K_FV = 4'b1000;
  localparam logic [3:0] K_OE = 4'b0100;
  localparam logic [3:0] K_ME = 4'b0010;
  localparam logic [3:0] K_TO = 4'b0001;

  typedef struct {
    logic [3:0]  kind;
    logic [15:0] dig;
    logic [7:0]  err;
    int          at;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [3:0] a_an = 4'hF, b_an = 4'hF;
  logic [3:0] a_ch = 4'h0, b_ch = 4'h0;
  logic [3:0] a_d0, a_d1, a_d2, a_d3, b_d0, b_d1, b_d2, b_d3;
  logic a_fv, a_oe, a_me, a_to, b_fv, b_oe, b_me, b_to;
  logic [7:0] a_err, b_err;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int err_m [2];
  logic [15:0] dig_m [2];
  exp_t q_a[$];
  exp_t q_b[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  anode_capture #(.MIN_ON(1), .TIMEOUT(TMO)) dut_a (
    .clk(clk), .reset(reset),
    .an0(a_an[0]), .an1(a_an[1]), .an2(a_an[2]), .an3(a_an[3]), .char(a_ch),
    .digit0(a_d0), .digit1(a_d1), .digit2(a_d2), .digit3(a_d3),
    .frame_valid(a_fv), .order_err(a_oe), .multi_err(a_me), .timeout(a_to),
    .err_cnt(a_err)
  );

  anode_capture #(.MIN_ON(2), .TIMEOUT(TMO)) dut_b (
    .clk(clk), .reset(reset),
    .an0(b_an[0]), .an1(b_an[1]), .an2(b_an[2]), .an3(b_an[3]), .char(b_ch),
    .digit0(b_d0), .digit1(b_d1), .digit2(b_d2), .digit3(b_d3),
    .frame_valid(b_fv), .order_err(b_oe), .multi_err(b_me), .timeout(b_to),
    .err_cnt(b_err)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic push(input bit b, input logic [3:0] k, input int at);
    exp_t e;
    if (k[2:0] != 3'b000 && err_m[b] < 255) err_m[b]++;
    e.kind = k;
    e.dig  = dig_m[b];
    e.err  = 8'(err_m[b]);
    e.at   = at;
    if (b) q_b.push_back(e);
    else   q_a.push_back(e);
  endtask

  task automatic score(input bit b, input logic [3:0] k, input logic [15:0] d, input logic [7:0] er);
    exp_t e;
    string nm;
    nm = b ? "dut_b_event" : "dut_a_event";
    checks++;
    if ((b && q_b.size() == 0) || (!b && q_a.size() == 0)) begin
      errors++;
      $display("FAIL %s unexpected kind=%b dig=%h err=%0d cyc=%0d", nm, k, d, er, cyc);
    end else begin
      if (b) e = q_b.pop_front();
      else   e = q_a.pop_front();
      if (k !== e.kind || d !== e.dig || er !== e.err || cyc != e.at) begin
        errors++;
        $display("FAIL %s got kind=%b dig=%h err=%0d cyc=%0d want kind=%b dig=%h err=%0d cyc=%0d",
                 nm, k, d, er, cyc, e.kind, e.dig, e.err, e.at);
      end
    end
  endtask

  // Monitor: any output pulse must match the head of its queue.
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        if ({a_fv, a_oe, a_me, a_to} != 4'b0000)
          score(1'b0, {a_fv, a_oe, a_me, a_to}, {a_d3, a_d2, a_d1, a_d0}, a_err);
        if ({b_fv, b_oe, b_me, b_to} != 4'b0000)
          score(1'b1, {b_fv, b_oe, b_me, b_to}, {b_d3, b_d2, b_d1, b_d0}, b_err);
      end
    end
  end

  // All stimulus tasks start and end on a falling edge.
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic strobe(input bit b, input int idx, input logic [3:0] ch, input int len, output int t0);
    if (b) begin b_an[idx] = 1'b0; b_ch = ch; end
    else   begin a_an[idx] = 1'b0; a_ch = ch; end
    t0 = cyc;
    repeat (len) @(negedge clk);
    if (b) b_an = 4'hF;
    else   a_an = 4'hF;
  endtask

  task automatic frame(input bit b, input logic [15:0] cs, input int len);
    int t;
    for (int i = 3; i >= 0; i--) begin
      strobe(b, i, cs[i*4 +: 4], len, t);
      if (i != 0) idle(3);
    end
    dig_m[b] = cs;
    push(b, K_FV, t + len + 2);
    idle(3);
  endtask

  task automatic burst(input logic [3:0] lows, input int n);
    int t;
    a_an = ~lows;
    t = cyc;
    for (int k = 0; k < n; k++) push(1'b0, K_ME, t + 2 + k);
    repeat (n) @(negedge clk);
    a_an = 4'hF;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q_a.size() + q_b.size()) != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if ((q_a.size() + q_b.size()) != 0) begin
      checks++;
      errors++;
      $display("FAIL drain pending a=%0d b=%0d events never seen", q_a.size(), q_b.size());
      q_a.delete();
      q_b.delete();
    end
    idle(4);
  endtask

  initial begin
    int t;
    err_m[0] = 0; err_m[1] = 0;
    dig_m[0] = '0; dig_m[1] = '0;
    idle(3);
    reset = 1'b1;
    idle(1);

    chk("rst_a_digits", {a_d3, a_d2, a_d1, a_d0}, 0);
    chk("rst_a_pulses", {a_fv, a_oe, a_me, a_to}, 0);
    chk("rst_a_err", a_err, 0);
    chk("rst_b_digits", {b_d3, b_d2, b_d1, b_d0}, 0);

    // Nominal 16-cycle scan, frames one period apart.
    frame(1'b0, {CH_ZERO, CH_ONE, CH_TWO, CH_THREE}, 1);
    frame(1'b0, {CH_ZERO, CH_ONE, CH_TWO, CH_THREE}, 1);
    frame(1'b0, {CH_NINE, CH_EIGHT, CH_SEVEN, CH_SIX}, 1);
    drain();

    // Order violation: 3 then 1, then a clean frame straight from WAIT3.
    strobe(1'b0, 3, CH_FOUR, 1, t); idle(3);
    strobe(1'b0, 1, CH_FIVE, 1, t);
    push(1'b0, K_OE, t + 3);
    idle(3);
    drain();
    frame(1'b0, 16'hABCD, 1);
    drain();

    // Two anodes low together for one cycle.
    burst(4'b0110, 1);
    drain();
    frame(1'b0, 16'h1234, 1);
    drain();

    // Timeout after digit 3, then digit 2 must be out of order.
    strobe(1'b0, 3, CH_SEVEN, 1, t);
    push(1'b0, K_TO, t + 1 + 2 + TMO + 1);
    drain();
    strobe(1'b0, 2, CH_ONE, 1, t);
    push(1'b0, K_OE, t + 3);
    drain();

    // MIN_ON=2: short glitch and unstable char are dropped silently.
    strobe(1'b1, 1, CH_NINE, 1, t); idle(3);
    b_an[2] = 1'b0; b_ch = CH_THREE; idle(1);
    b_ch = CH_FOUR; idle(2);
    b_an = 4'hF; idle(3);
    frame(1'b1, 16'h2468, 2);
    drain();

    // Saturating error counter.
    burst(4'b1001, 254 - err_m[0]);
    drain();
    chk("err_at_254", a_err, 254);
    burst(4'b1001, 3);
    drain();
    chk("err_sat_255", a_err, 255);

    // Asynchronous reset mid-frame.
    strobe(1'b0, 3, CH_ONE, 1, t); idle(3);
    strobe(1'b0, 2, CH_TWO, 1, t); idle(5);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_a_digits", {a_d3, a_d2, a_d1, a_d0}, 0);
    chk("mid_rst_a_err", a_err, 0);
    chk("mid_rst_b_digits", {b_d3, b_d2, b_d1, b_d0}, 0);
    err_m[0] = 0; err_m[1] = 0;
    dig_m[0] = '0; dig_m[1] = '0;
    @(negedge clk);
    reset = 1'b1;
    idle(2);
    strobe(1'b0, 1, CH_THREE, 1, t);
    push(1'b0, K_OE, t + 3);
    idle(3);
    strobe(1'b0, 0, CH_FOUR, 1, t);
    push(1'b0, K_OE, t + 3);
    idle(3);
    drain();
    frame(1'b0, 16'h5678, 1);
    drain();
    idle(20);
    chk("final_err_a", a_err, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
